// File: rtl/fifo_uart_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_pkg
// Shared types and constants for the FIFO-drain UART transmitter.
//   fifo_uart_state_t : transmitter FSM state encoding
//   DATA_W            : byte width, matches the upstream 16-entry FIFO
//   FRAME_BITS        : bits per 8N1 frame (start + 8 data + stop)
// -----------------------------------------------------------------------------
package fifo_uart_pkg;

    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } fifo_uart_state_t;

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Counts clk cycles within one UART bit period.
//   clk  : clock
//   rst  : synchronous active-high reset
//   clr  : force the count back to 0 (used whenever the FSM is not timing a bit)
//   en   : advance the count
//   tick : high on the last cycle of each bit period
// -----------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Wrapping at LAST means every new bit (and therefore every timed state
    // entered on a tick) starts again from 0.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Drains the 16-entry byte FIFO one byte at a time and sends each byte as an
// 8N1 UART frame, LSB first.
//   clk, rst    : clock, synchronous active-high reset
//   fifo_empty  : FIFO empty flag
//   fifo_full   : FIFO full flag
//   fifo_wr     : copy of the FIFO write strobe (a write wins over our pop)
//   fifo_dout   : FIFO registered read data, valid the cycle after the pop
//   fifo_rd     : pop request, high only in REQ
//   tx          : serial line, idle high, driven from a flop
//   busy        : high whenever the FSM is not IDLE
//   byte_done   : one-cycle pulse on the last stop-bit cycle
//
// state | meaning
// IDLE  | line idle, waiting for the FIFO to become non-empty
// REQ   | pop issued; falls back to IDLE if a concurrent write blocks it
// WAIT  | popped byte appears on fifo_dout, load shift register
// START | start bit (tx=0)
// DATA  | eight data bits, LSB first
// STOP  | stop bit (tx=1), byte_done on its final cycle
// -----------------------------------------------------------------------------
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    input  logic              fifo_wr,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              byte_done
);

    fifo_uart_state_t    state_q;
    logic [DATA_W-1:0]   shreg_q;
    logic [2:0]          bit_idx_q;
    logic                tx_q;
    logic                tick;
    logic                timing;
    logic                pop_ok;

    // The FIFO ignores a read in any cycle where it accepts a write, so a pop
    // only counts when no write is landing at the same edge.
    assign pop_ok = !fifo_empty && !(fifo_wr && !fifo_full);

    // Timer only runs in the bit-timed states; holding it cleared elsewhere
    // makes START always begin from a zero count.
    assign timing = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (!timing),
        .en   (timing),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    state_q <= pop_ok ? WAIT : IDLE;
                end
                WAIT: begin
                    shreg_q <= fifo_dout;
                    tx_q    <= 1'b0;
                    state_q <= START;
                end
                START: begin
                    if (tick) begin
                        tx_q      <= shreg_q[0];
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            // tx takes the next bit while the register shifts
                            shreg_q   <= shreg_q >> 1;
                            tx_q      <= shreg_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Decoded purely from registers, so no input reaches these outputs.
    assign tx        = tx_q;
    assign fifo_rd   = (state_q == REQ);
    assign busy      = (state_q != IDLE);
    assign byte_done = (state_q == STOP) && tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Drives fifo_uart_tx from a behavioural 16-entry FIFO (write beats read) and
// decodes the serial line with an independent UART receiver. Bytes accepted
// by the FIFO are queued as expected frames; the receiver pops and compares.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_wr = 1'b0;
    logic [7:0] fifo_din = 8'h00;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_empty, fifo_full, fifo_rd, tx, busy, byte_done;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .byte_done  (byte_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural FIFO: a write accepted in a cycle suppresses any read.
    logic [7:0] mem [16];
    logic [3:0] wp = 4'd0;
    logic [3:0] rp = 4'd0;
    int         cnt = 0;
    assign fifo_empty = (cnt == 0);
    assign fifo_full  = (cnt == 16);

    always @(posedge clk) begin
        if (fifo_wr && !fifo_full) begin
            mem[wp] <= fifo_din;
            wp      <= wp + 4'd1;
            cnt     <= cnt + 1;
        end else if (fifo_rd && !fifo_empty) begin
            fifo_dout <= mem[rp];
            rp        <= rp + 4'd1;
            cnt       <= cnt - 1;
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    logic [7:0] exp_q [$];

    int rd_pulses = 0;
    int rd_empty_viol = 0;
    always @(negedge clk) begin
        if (fifo_rd) rd_pulses++;
        if (fifo_rd && fifo_empty) rd_empty_viol++;
    end

    // Independent UART receiver / scoreboard consumer.
    bit         mon_en = 1'b0;
    bit         gap_chk = 1'b0;
    int         prev_end = -1;
    int         mon_start;
    logic [7:0] mon_rx;
    logic [7:0] mon_exp;
    logic       mon_lvl;
    bit         mon_shape_ok;
    bit         mon_done_ok;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && tx == 1'b0) begin
                mon_start    = cyc;
                mon_shape_ok = 1'b1;
                mon_done_ok  = 1'b1;
                mon_rx       = 8'h00;
                mon_lvl      = 1'b0;
                if (gap_chk && prev_end >= 0)
                    chk("frame_gap", mon_start - prev_end - 1, 3);
                for (int b = 0; b < 10; b++) begin
                    for (int k = 0; k < CPB; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (k == 0) mon_lvl = tx;
                        else if (tx !== mon_lvl) mon_shape_ok = 1'b0;
                        if (byte_done !== ((b == 9) && (k == CPB - 1))) mon_done_ok = 1'b0;
                    end
                    if (b == 0 && mon_lvl !== 1'b0) mon_shape_ok = 1'b0;
                    if (b == 9 && mon_lvl !== 1'b1) mon_shape_ok = 1'b0;
                    if (b >= 1 && b <= 8) mon_rx[b-1] = mon_lvl;
                end
                prev_end = cyc;
                chk("frame_bits_held", int'(mon_shape_ok), 1);
                chk("byte_done_at_cycle_40", int'(mon_done_ok), 1);
                if (exp_q.size() == 0) begin
                    chk("frame_unexpected", int'(mon_rx), -1);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("frame_data", int'(mon_rx), int'(mon_exp));
                end
            end
        end
    end

    // One clock of stimulus; a write is only offered when the FIFO has room.
    task automatic step(input bit en, input logic [7:0] v);
        if (en && cnt < 16) begin
            fifo_wr  = 1'b1;
            fifo_din = v;
            exp_q.push_back(v);
        end else begin
            fifo_wr = 1'b0;
        end
        @(posedge clk);
        #1;
        fifo_wr = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !busy && fifo_empty) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < 4000) ? 1 : 0, 1);
        @(posedge clk);
        #1;
    endtask

    int c0, cs, rd0, idle_bad;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_fifo_rd", int'(fifo_rd), 0);
        chk("reset_byte_done", int'(byte_done), 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single byte, then the block must stay idle on an empty FIFO.
        rd0 = rd_pulses;
        step(1'b1, 8'hA5);
        c0 = cyc;
        cs = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cs < 0 && tx == 1'b0) cs = cyc;
        end
        chk("single_rd_pulses", rd_pulses - rd0, 1);
        chk("single_start_latency", cs - c0, 3);
        idle_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy || fifo_rd) idle_bad++;
        end
        chk("single_stays_idle", idle_bad, 0);
        wait_drain("single_drain");

        // Three back-to-back writes: the first pop collides with a write.
        rd0 = rd_pulses;
        step(1'b1, 8'h11);
        c0 = cyc;
        step(1'b1, 8'h22);
        step(1'b1, 8'h33);
        cs = -1;
        for (int i = 0; i < 30 && cs < 0; i++) begin
            @(negedge clk);
            if (tx == 1'b0) cs = cyc;
        end
        chk("suppressed_start_latency", cs - c0, 5);
        chk("suppressed_rd_pulses", rd_pulses - rd0, 2);
        wait_drain("suppressed_drain");

        // Burst of 16: fill, then drain with fixed inter-frame gaps.
        prev_end = -1;
        gap_chk  = 1'b1;
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i));
        chk("burst_fifo_full", int'(fifo_full), 1);
        wait_drain("burst_drain");
        gap_chk = 1'b0;
        @(negedge clk);
        chk("burst_end_empty", int'(fifo_empty), 1);
        chk("burst_end_busy", int'(busy), 0);
        @(posedge clk);
        #1;

        // Random writes with random spacing.
        for (int n = 0; n < 40; n++) begin
            int g;
            g = $urandom_range(0, 5);
            repeat (g) step(1'b0, 8'h00);
            step(1'b1, 8'($urandom));
        end
        wait_drain("random_drain");

        // Reset during data bit 3; the popped byte is lost, the next one sent.
        mon_en = 1'b0;
        step(1'b1, 8'h3C);
        step(1'b1, 8'h5A);
        cs = -1;
        for (int i = 0; i < 20 && cs < 0; i++) begin
            @(negedge clk);
            if (tx == 1'b0) cs = cyc;
        end
        chk("rst_frame_started", (cs >= 0) ? 1 : 0, 1);
        repeat (4 * CPB + 1) @(negedge clk);
        chk("rst_mid_bit3_level", int'(tx), 1);
        chk("rst_mid_busy", int'(busy), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_next_tx", int'(tx), 1);
        chk("rst_next_busy", int'(busy), 0);
        chk("rst_next_fifo_rd", int'(fifo_rd), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        mon_en = 1'b1;
        wait_drain("rst_recover_drain");

        chk("rd_while_empty", rd_empty_viol, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the 16-entry byte FIFO. Pops one byte at a time through the FIFO's rd/dout/empty interface and serializes it as an 8N1 UART frame on `tx`. It accounts for the FIFO's write-over-read priority so that no byte is lost or duplicated. The block sits between the FIFO and the chip-level serial pin.

## Interface
- CLKS_PER_BIT, 16: clk cycles per UART bit; legal range ≥ 2.
- DATA_W, 8: byte width; fixed at 8 to match the FIFO.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_full  in  1  FIFO full flag.
- fifo_wr  in  1  copy of the FIFO's wr input, used to detect a suppressed pop.
- fifo_dout  in  8  FIFO registered read data.
- fifo_rd  out  1  pop request to the FIFO.
- tx  out  1  serial line, idle high.
- busy  out  1  high whenever state ≠ IDLE.
- byte_done  out  1  one-cycle pulse on the last cycle of the stop bit.

## Operation
- States: IDLE, REQ, WAIT, START, DATA, STOP.
- IDLE: if fifo_empty=0 → REQ; otherwise stay.
- REQ:
  - fifo_rd=1. It is decoded from the state register only, with no combinational path from inputs.
  - Pop is accepted iff fifo_empty=0 && !(fifo_wr && !fifo_full), sampled in this cycle.
  - Accepted → WAIT.
  - Rejected (write took priority) → IDLE, then retry. No data is latched.
- WAIT: fifo_dout is valid this cycle. Latch it into an 8-bit shift register → START.
- START: tx=0 for CLKS_PER_BIT cycles → DATA.
- DATA:
  - 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - The shift register shifts right at each bit boundary.
  - A 3-bit index counts 0..7; after bit 7 → STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - byte_done=1 on the final cycle → IDLE.
- fifo_rd is 0 in every state except REQ.
- Bit timer: counter width $clog2(CLKS_PER_BIT). It reloads to 0 on every state entry and wraps at CLKS_PER_BIT-1.
- Reset value of every output: fifo_rd=0, tx=1, busy=0, byte_done=0. State = IDLE, counters = 0.
- Reset mid-frame: the next cycle has tx=1 and state=IDLE. The popped byte is discarded and is not re-read.
- The FIFO being empty or full during a frame has no effect. The block only samples the flags in IDLE and REQ.

## Timing
- Cycle 0: IDLE sees fifo_empty=0.
- Cycle 1: REQ, fifo_rd=1.
- Cycle 2: WAIT.
- Cycle 3: first START cycle, tx=0.
- Frame length: exactly 10×CLKS_PER_BIT cycles, from the first START cycle to the last STOP cycle.
- Back-to-back bytes: STOP → IDLE → REQ → WAIT → START. The idle-high gap between frames is 3 cycles beyond the stop bit.
- Each rejected pop adds 2 cycles (REQ → IDLE → REQ).
- tx is driven from a register and is glitch-free.

## Structure
- Package fifo_uart_pkg holds:
  - state enum fifo_uart_state_t (6 states, 3 bits);
  - localparam DATA_W=8;
  - localparam FRAME_BITS=10.
- One sub-module, uart_bit_timer:
  - parameter CLKS_PER_BIT;
  - inputs clr and en;
  - output tick, asserted on the last cycle of each bit period.
- The FSM, shift register and bit index live in fifo_uart_tx.

## Test plan
All scenarios run with CLKS_PER_BIT=4.
- **Single byte.** Push 0xA5 into an empty FIFO. Required:
  - fifo_rd for exactly 1 cycle;
  - tx = 0, 1,0,1,0,0,1,0,1, 1, each bit held 4 cycles;
  - start bit begins 3 cycles after fifo_empty falls;
  - byte_done pulses at cycle 40 of the frame.
- **Burst of 16.** Fill the FIFO with 0x00..0x0F, then stop writing. Required:
  - 16 frames in order;
  - 3-cycle gap between consecutive frames;
  - fifo_empty=1 and busy=0 after the last byte_done.
- **Suppressed pop.** Hold fifo_wr=1 (FIFO not full) during the REQ cycle. Required:
  - block returns to IDLE and retries;
  - exactly one byte is serialized per successful pop, with no duplicate and no skip (checked against a scoreboard).
- **Reset mid-frame.** Assert rst during DATA bit 3. Required:
  - the next cycle has tx=1, busy=0, fifo_rd=0;
  - after release, the next FIFO byte is sent as a complete frame.
- **Empty after pop.** FIFO holds a single byte. Required:
  - after its frame, the block stays in IDLE;
  - fifo_rd is never asserted while fifo_empty=1.
